// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - parametrised pipeline stage register with optional skid entry
// Holds up to two payloads under valid/ready; flush turns the stage into a bubble.
module pipe_stage_skid #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
  parameter bit                SKID    = 1'b1
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_accept;
  logic              w_emit;

  assign w_accept = in_valid & in_ready;
  assign w_emit   = out_valid & out_ready;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state <= ST_EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RST_VAL;
      w_skid_nxt  = RST_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_emit) begin
            w_main_nxt = in_data;
          end else if (w_accept && SKID) begin
            // Downstream stalled: park the newcomer behind the main entry.
            w_skid_nxt  = in_data;
            w_state_nxt = ST_FULL;
          end else if (w_emit) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_emit) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Skid mode keeps in_ready purely registered; single-entry mode looks through to out_ready.
  assign in_ready  = SKID ? (r_state != ST_FULL) : (out_ready | ~out_valid);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = out_valid ? r_main : RST_VAL;

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule
